// File: rtl/mux_arb_pkg.sv
// Shared arbitration types and helpers: grant-mode constants, index width helper,
// and a rotated first-set-bit search used by the channel arbiters.
package mux_arb_pkg;

  typedef enum logic {
    RR    = 1'b0,
    FIXED = 1'b1
  } grant_mode_e;

  localparam int MAX_N = 64;

  typedef struct packed {
    logic       found;
    logic [5:0] idx;
  } arb_res_t;

  function automatic int selw_of(input int n);
    return $clog2(n);
  endfunction

  // First set bit of vec[n-1:0] searching upward from start, wrapping n-1 -> 0.
  function automatic arb_res_t onehot_first_from(input logic [MAX_N-1:0] vec,
                                                 input int n,
                                                 input logic [5:0] start);
    arb_res_t r;
    r = '0;
    for (int j = 0; j < MAX_N; j++) begin
      if (!r.found && j < n && j >= int'(start) && vec[j]) begin
        r.found = 1'b1;
        r.idx   = 6'(j);
      end
    end
    for (int j = 0; j < MAX_N; j++) begin
      if (!r.found && j < n && j < int'(start) && vec[j]) begin
        r.found = 1'b1;
        r.idx   = 6'(j);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_nway_arb_chip_rr_arbiter.sv
// Combinational rotated-priority arbiter: eligible vector + search start -> grant index.
module rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int N    = 8,
  parameter int SELW = selw_of(N)
) (
  input  logic [N-1:0]    elig_i,
  input  logic [SELW-1:0] start_i,
  output logic [SELW-1:0] grant_o,
  output logic            grant_vld_o
);

  arb_res_t res;

  always_comb begin
    res         = onehot_first_from(MAX_N'(elig_i), N, 6'(start_i));
    grant_o     = SELW'(res.idx);
    grant_vld_o = res.found;
  end

endmodule

// File: rtl/mux_nway_arb_chip.sv
// N-way valid/ready channel merger with a registered output and round-robin arbitration.
// Define MUX_ARB_FIXED_PRIO_EN to drop the pointer and use fixed lowest-index priority.
module mux_nway_arb_chip
  import mux_arb_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int N     = 8,
  localparam int SELW  = selw_of(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic               force_en,
  input  logic [SELW-1:0]    force_sel,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SELW-1:0]    out_sel
);

`ifdef MUX_ARB_FIXED_PRIO_EN
  localparam grant_mode_e GRANT_MODE = FIXED;
`else
  localparam grant_mode_e GRANT_MODE = RR;
`endif

  logic [N-1:0]     elig;
  logic [SELW-1:0]  search_start;
  logic [SELW-1:0]  grant;
  logic             grant_vld;
  logic             space;
  logic             xfer;

  logic [WIDTH-1:0] data_q, data_d;
  logic [SELW-1:0]  sel_q, sel_d;
  logic             valid_q, valid_d;

  // An out-of-range force_sel leaves nothing eligible rather than aliasing a channel.
  always_comb begin
    elig = '0;
    if (force_en) begin
      if (int'(force_sel) < N) elig = in_valid & (N'(1) << force_sel);
    end else begin
      elig = in_valid;
    end
  end

  rr_arbiter #(
    .N    (N),
    .SELW (SELW)
  ) u_arb (
    .elig_i      (elig),
    .start_i     (search_start),
    .grant_o     (grant),
    .grant_vld_o (grant_vld)
  );

  generate
    if (GRANT_MODE == RR) begin : g_rr
      logic [SELW-1:0] ptr_q, ptr_d;

      always_comb begin
        ptr_d = ptr_q;
        if (xfer) ptr_d = (grant == SELW'(N - 1)) ? '0 : grant + SELW'(1);
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
      end

      assign search_start = ptr_q;
    end else begin : g_fixed
      assign search_start = '0;
    end
  endgenerate

  assign space    = !valid_q || out_ready;
  assign xfer     = space && grant_vld;
  assign in_ready = (xfer && !reset) ? (N'(1) << grant) : '0;

  always_comb begin
    data_d  = data_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    if (xfer) begin
      data_d  = in_data[int'(grant)*WIDTH +: WIDTH];
      sel_d   = grant;
      valid_d = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = data_q;
  assign out_sel   = sel_q;
  assign out_valid = valid_q;

endmodule
